wb_gpio_pinmux: RTL
===================

Name: wb_gpio_pinmux

Overview:
- Wishbone classic slave that owns a parametrised bank of bidirectional board pins.
- Per-pin features: direction and output data, N-stage input synchroniser, alternate-function override for on-chip peripherals (e.g. UART tx/rx), and edge-triggered interrupts.
- Sits between the SoC Wishbone interconnect and the board top-level tristate pad logic.
- Replaces hard-wired GPIO-to-peripheral assigns in board tops.

Parameters:
GPIO_WIDTH, 8, number of pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..4)
RESET_DIR, 0, reset value of DIR register (bit=1 output)
RESET_OUT, 0, reset value of DATA_OUT register

Ports:
wb_clk  in  1  single clock
wb_rst_n  in  1  asynchronous, active-low reset
wb_adr_i  in  6  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
gpio_i  in  GPIO_WIDTH  raw pad input
gpio_o  out  GPIO_WIDTH  pad output value
gpio_oe  out  GPIO_WIDTH  pad output enable (1=drive)
alt_o_i  in  GPIO_WIDTH  peripheral output per pin
alt_oe_i  in  GPIO_WIDTH  peripheral output enable per pin
alt_i_o  out  GPIO_WIDTH  synchronised pin value to peripherals
irq_o  out  1  level interrupt

Behaviour:
- Reset is asynchronous, active-low on wb_rst_n, one clock wb_clk. All flops clear on reset.
- Register reset values: DATA_OUT=RESET_OUT, DIR=RESET_DIR, all others 0.
- Output reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0, sync chain 0.
- Register map (word offsets); bits above GPIO_WIDTH read 0 and ignore writes:
  - 0x00 DATA_OUT, RW
  - 0x04 DIR, RW
  - 0x08 DATA_IN, RO (last sync stage)
  - 0x0C ALT_EN, RW
  - 0x10 IRQ_MASK, RW
  - 0x14 IRQ_EDGE, RW (1=rising, 0=falling)
  - 0x18 IRQ_STATUS, RW1C
- Unmapped offsets: ack, read 0, writes ignored.
- Bus handshake:
  - wb_ack_o rises one cycle after cyc&stb&!ack and is high for exactly one cycle.
  - Back-to-back requests ack every other cycle.
  - Read data is registered and valid with ack.
  - Writes take effect on the ack edge, honouring wb_sel_i per byte.
  - Dropping cyc mid-request: a pending ack still pulses once; the write is already committed.
- Pad mux (combinational from registers/inputs):
  - gpio_o[i] = ALT_EN[i] ? alt_o_i[i] : DATA_OUT[i]
  - gpio_oe[i] = ALT_EN[i] ? alt_oe_i[i] : DIR[i]
- Input path:
  - gpio_i passes through SYNC_STAGES flops; alt_i_o = DATA_IN.
  - Latency from pad to DATA_IN is SYNC_STAGES cycles.
- Edge detect:
  - prev register holds the last DATA_IN.
  - rise = DATA_IN & ~prev; fall = ~DATA_IN & prev.
  - IRQ_STATUS[i] sets on the selected edge regardless of mask.
- Priming:
  - Counter prime_cnt counts 0..SYNC_STAGES+1 after reset release.
  - Edge detection is suppressed until the counter saturates, so pins high at reset produce no spurious edge.
- Simultaneous W1C and new edge on the same bit: set wins, bit stays 1.
- irq_o is registered: irq_o = |(IRQ_STATUS & IRQ_MASK), one cycle after status/mask change.
- Changing IRQ_EDGE does not clear IRQ_STATUS.
- Reset mid-transaction: ack drops immediately and the write is lost.

Optional Feature:
- Macro: GPIO_PINMUX_ATOMIC_SETCLR_EN.
- Defined: adds write-only 0x1C DATA_SET (DATA_OUT |= wdat) and 0x20 DATA_CLR (DATA_OUT &= ~wdat).
  - Both read 0 and obey wb_sel_i.
  - Atomic single-cycle update; no read-modify-write hazard with ISRs.
- Undefined: 0x1C/0x20 behave as unmapped (ack, read 0, no effect).

Decomposition:
- Package gpio_pinmux_pkg: register offset constants (REG_DATA_OUT..REG_DATA_CLR), MAX_GPIO_WIDTH=32.
- One sub-module: gpio_sync_edge, per-bank synchroniser plus prev register plus priming counter. It outputs DATA_IN, rise and fall vectors.

Test Plan:
- Reset, then read all registers -> DIR=RESET_DIR, DATA_OUT=RESET_OUT, others 0; gpio_i held 0xFF through reset -> no IRQ_STATUS bits set.
- Write DIR=0x0F, DATA_OUT=0xA5 -> gpio_oe=0x0F, gpio_o=0xA5; write with wb_sel_i=0 -> registers unchanged, ack still pulses once.
- ALT_EN=0x02, alt_o_i[1] toggling, alt_oe_i[1]=1 -> gpio_o[1] follows alt_o_i same cycle, gpio_oe[1]=1; gpio_i[3] 0->1 -> alt_i_o[3]=1 after exactly SYNC_STAGES cycles.
- IRQ_EDGE=0x01, IRQ_MASK=0x01, gpio_i[0] rises -> IRQ_STATUS=0x01 and irq_o=1 one cycle later; write 0x01 to IRQ_STATUS -> irq_o=0; falling edge -> no set.
- W1C of bit 0 in the same cycle a new rising edge on pin 0 is detected -> IRQ_STATUS[0] stays 1, irq_o stays 1.
- With GPIO_PINMUX_ATOMIC_SETCLR_EN: DATA_OUT=0x0F, write DATA_SET=0x30 -> 0x3F, write DATA_CLR=0x03 -> 0x3C. Without the macro, the same writes leave DATA_OUT=0x0F.

Source files
------------

// File: rtl/gpio_pinmux_pkg.sv
// Shared constants for the Wishbone GPIO pin-mux: register word indices and a
// byte-enable expansion helper.
package gpio_pinmux_pkg;

   localparam int MAX_GPIO_WIDTH = 32;

   // Word indices (byte offset >> 2)
   localparam logic [3:0] REG_DATA_OUT   = 4'h0;
   localparam logic [3:0] REG_DIR        = 4'h1;
   localparam logic [3:0] REG_DATA_IN    = 4'h2;
   localparam logic [3:0] REG_ALT_EN     = 4'h3;
   localparam logic [3:0] REG_IRQ_MASK   = 4'h4;
   localparam logic [3:0] REG_IRQ_EDGE   = 4'h5;
   localparam logic [3:0] REG_IRQ_STATUS = 4'h6;
   localparam logic [3:0] REG_DATA_SET   = 4'h7;
   localparam logic [3:0] REG_DATA_CLR   = 4'h8;

   function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Bank-wide input synchroniser, previous-value register and priming counter;
// edges are held off until the chain is full so pins high at reset stay quiet.
module gpio_sync_edge
   import gpio_pinmux_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pins,
   output logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int                CNT_W      = $clog2(STAGES + 2);
   localparam logic [CNT_W-1:0]  PRIME_DONE = CNT_W'(STAGES + 1);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]             prev_q;
   logic [CNT_W-1:0]             prime_cnt;
   logic                         primed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= '0;
         prime_cnt <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pins};
         prev_q <= data_in;
         if (!primed) prime_cnt <= prime_cnt + 1'b1;
      end
   end

   assign data_in = sync_q[STAGES-1];
   assign primed  = (prime_cnt == PRIME_DONE);
   assign rise    = primed ? (data_in & ~prev_q) : '0;
   assign fall    = primed ? (~data_in & prev_q) : '0;

endmodule

// File: rtl/wb_gpio_pinmux.sv
// Wishbone classic GPIO bank with alternate-function pad mux and edge IRQs.
// Define GPIO_PINMUX_ATOMIC_SETCLR_EN to add the DATA_SET/DATA_CLR registers.
module wb_gpio_pinmux
   import gpio_pinmux_pkg::*;
#(
   parameter int                        GPIO_WIDTH  = 8,
   parameter int                        SYNC_STAGES = 2,
   parameter logic [MAX_GPIO_WIDTH-1:0] RESET_DIR   = '0,
   parameter logic [MAX_GPIO_WIDTH-1:0] RESET_OUT   = '0
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst_n,
   input  logic [5:0]            wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   input  logic [GPIO_WIDTH-1:0] alt_o_i,
   input  logic [GPIO_WIDTH-1:0] alt_oe_i,
   output logic [GPIO_WIDTH-1:0] alt_i_o,
   output logic                  irq_o
);

   logic [GPIO_WIDTH-1:0] data_out_q, dir_q, alt_en_q, irq_mask_q, irq_edge_q, irq_status_q;
   logic [GPIO_WIDTH-1:0] data_in, rise, fall, edge_hit, wmask, wdata, w1c;
   logic [31:0]           byte_mask, rdata;
   logic [3:0]            reg_idx;
   logic                  req, wr;
   logic                  unused_bits;

   assign reg_idx   = wb_adr_i[5:2];
   assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr        = req & wb_we_i;
   assign byte_mask = sel_to_mask(wb_sel_i);
   assign wmask     = byte_mask[GPIO_WIDTH-1:0];
   assign wdata     = wb_dat_i[GPIO_WIDTH-1:0] & wmask;
   assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i, byte_mask};

   gpio_sync_edge #(
      .WIDTH  (GPIO_WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (wb_clk),
      .rst_n   (wb_rst_n),
      .pins    (gpio_i),
      .data_in (data_in),
      .rise    (rise),
      .fall    (fall)
   );

   always_comb begin
      rdata = '0;
      case (reg_idx)
         REG_DATA_OUT:   rdata[GPIO_WIDTH-1:0] = data_out_q;
         REG_DIR:        rdata[GPIO_WIDTH-1:0] = dir_q;
         REG_DATA_IN:    rdata[GPIO_WIDTH-1:0] = data_in;
         REG_ALT_EN:     rdata[GPIO_WIDTH-1:0] = alt_en_q;
         REG_IRQ_MASK:   rdata[GPIO_WIDTH-1:0] = irq_mask_q;
         REG_IRQ_EDGE:   rdata[GPIO_WIDTH-1:0] = irq_edge_q;
         REG_IRQ_STATUS: rdata[GPIO_WIDTH-1:0] = irq_status_q;
         default:        rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= req;
         wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
      end
   end

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         data_out_q <= RESET_OUT[GPIO_WIDTH-1:0];
         dir_q      <= RESET_DIR[GPIO_WIDTH-1:0];
         alt_en_q   <= '0;
         irq_mask_q <= '0;
         irq_edge_q <= '0;
      end else if (wr) begin
         case (reg_idx)
            REG_DATA_OUT: data_out_q <= (data_out_q & ~wmask) | wdata;
            REG_DIR:      dir_q      <= (dir_q      & ~wmask) | wdata;
            REG_ALT_EN:   alt_en_q   <= (alt_en_q   & ~wmask) | wdata;
            REG_IRQ_MASK: irq_mask_q <= (irq_mask_q & ~wmask) | wdata;
            REG_IRQ_EDGE: irq_edge_q <= (irq_edge_q & ~wmask) | wdata;
`ifdef GPIO_PINMUX_ATOMIC_SETCLR_EN
            REG_DATA_SET: data_out_q <= data_out_q | wdata;
            REG_DATA_CLR: data_out_q <= data_out_q & ~wdata;
`endif
            default: ;
         endcase
      end
   end

   // New edges are OR-ed after the W1C so a coincident set wins.
   assign w1c      = (wr && reg_idx == REG_IRQ_STATUS) ? wdata : '0;
   assign edge_hit = (rise & irq_edge_q) | (fall & ~irq_edge_q);

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         irq_status_q <= '0;
         irq_o        <= 1'b0;
      end else begin
         irq_status_q <= (irq_status_q & ~w1c) | edge_hit;
         irq_o        <= |(irq_status_q & irq_mask_q);
      end
   end

   assign gpio_o  = (alt_en_q & alt_o_i)  | (~alt_en_q & data_out_q);
   assign gpio_oe = (alt_en_q & alt_oe_i) | (~alt_en_q & dir_q);
   assign alt_i_o = data_in;

endmodule
